// File: rtl/esm_pkg.sv
// rtl/esm_pkg.sv - shared types and constants for the ESM dispatch buffer
package esm_pkg;

    localparam int BS = 16;
    localparam int IW = 32;
    localparam int RW = 5;

    function automatic int bs_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BS_BITS = bs_bits(BS);

    localparam logic [RW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] instr;
        logic [RW-1:0] rd;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
    } slot_entry_t;

endpackage

// File: rtl/esm_hazard_check.sv
// rtl/esm_hazard_check.sv - RAW/WAW/WAR dependency of slot i on an older slot j
module esm_hazard_check
    import esm_pkg::*;
#(
    parameter int rw = RW
) (
    input  logic [rw-1:0] rd_i,
    input  logic [rw-1:0] rs1_i,
    input  logic [rw-1:0] rs2_i,
    input  logic [rw-1:0] rd_j,
    input  logic [rw-1:0] rs1_j,
    input  logic [rw-1:0] rs2_j,
    input  logic          valid_j,
    input  logic          older_ij,
    output logic          dep
);

    logic raw;
    logic waw;
    logic war;

    always_comb begin
        raw = (rd_j != rw'(REG_ZERO)) && ((rd_j == rs1_i) || (rd_j == rs2_i));
        waw = (rd_i != rw'(REG_ZERO)) && (rd_j == rd_i);
        war = (rd_i != rw'(REG_ZERO)) && ((rs1_j == rd_i) || (rs2_j == rd_i));
        dep = valid_j && older_ij && (raw || waw || war);
    end

endmodule

// File: rtl/esm_dispatch_buffer.sv
// rtl/esm_dispatch_buffer.sv - age-ordered instruction buffer with hazard bitmap and grant-driven dispatch
// Optional ESM_DISPATCH_STATS_EN adds stat_dispatched/stat_dropped counters.
module esm_dispatch_buffer
    import esm_pkg::*;
#(
    parameter int bs = BS,
    parameter int iw = IW,
    parameter int rw = RW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [iw-1:0]          in_instr,
    input  logic [rw-1:0]          in_rd,
    input  logic [rw-1:0]          in_rs1,
    input  logic [rw-1:0]          in_rs2,
    output logic [0:bs-1]          independent_instr,
    input  logic [bs_bits(bs)-1:0] next_buffer_index,
    input  logic                   valid_count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [iw-1:0]          out_instr,
    output logic [bs_bits(bs)-1:0] out_index
`ifdef ESM_DISPATCH_STATS_EN
    ,
    output logic [31:0]            stat_dispatched,
    output logic [31:0]            stat_dropped
`endif
);

    localparam int SW = bs_bits(bs);

    slot_entry_t   slots_q [bs];
    slot_entry_t   slots_d [bs];
    // older_q[i][j] set means slot j was already buffered when slot i was written
    logic [bs-1:0] older_q [bs];
    logic [bs-1:0] older_d [bs];
    logic [bs-1:0] dep_m   [bs];

    logic          out_valid_q, out_valid_d;
    logic [iw-1:0] out_instr_q, out_instr_d;
    logic [SW-1:0] out_index_q, out_index_d;

    logic [bs-1:0] valid_vec;
    logic [0:bs-1] indep;
    logic          any_free;
    logic [SW-1:0] free_idx;
    logic          insert_fire;
    logic          grant_acc;

    for (genvar gi = 0; gi < bs; gi++) begin : g_row
        for (genvar gj = 0; gj < bs; gj++) begin : g_col
            esm_hazard_check #(.rw(rw)) u_hazard (
                .rd_i     (slots_q[gi].rd),
                .rs1_i    (slots_q[gi].rs1),
                .rs2_i    (slots_q[gi].rs2),
                .rd_j     (slots_q[gj].rd),
                .rs1_j    (slots_q[gj].rs1),
                .rs2_j    (slots_q[gj].rs2),
                .valid_j  (slots_q[gj].valid),
                .older_ij (older_q[gi][gj]),
                .dep      (dep_m[gi][gj])
            );
        end
        assign valid_vec[gi] = slots_q[gi].valid;
        assign indep[gi]     = slots_q[gi].valid && !(|dep_m[gi]);
    end

    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int k = bs - 1; k >= 0; k--) begin
            if (!valid_vec[k]) begin
                free_idx = SW'(k);
                any_free = 1'b1;
            end
        end
    end

    always_comb begin
        insert_fire = in_valid && any_free;
        grant_acc   = valid_count && valid_vec[next_buffer_index] &&
                      indep[next_buffer_index] && (!out_valid_q || out_ready);
    end

    always_comb begin
        for (int k = 0; k < bs; k++) begin
            slots_d[k] = slots_q[k];
            older_d[k] = older_q[k];
        end
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_index_d = out_index_q;

        if (grant_acc) begin
            slots_d[next_buffer_index].valid = 1'b0;
            for (int k = 0; k < bs; k++) begin
                older_d[k][next_buffer_index] = 1'b0;
            end
            out_valid_d = 1'b1;
            out_instr_d = slots_q[next_buffer_index].instr;
            out_index_d = next_buffer_index;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // The free slot is never the granted one, so insert and grant touch disjoint slots
        if (insert_fire) begin
            slots_d[free_idx] = '{valid: 1'b1, instr: in_instr, rd: in_rd,
                                  rs1: in_rs1, rs2: in_rs2};
            for (int k = 0; k < bs; k++) begin
                older_d[k][free_idx] = 1'b0;
            end
            older_d[free_idx] = valid_vec;
            if (grant_acc) begin
                older_d[free_idx][next_buffer_index] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < bs; k++) begin
                slots_q[k] <= '0;
                older_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_index_q <= '0;
        end else begin
            for (int k = 0; k < bs; k++) begin
                slots_q[k] <= slots_d[k];
                older_q[k] <= older_d[k];
            end
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_index_q <= out_index_d;
        end
    end

    assign in_ready          = any_free;
    assign independent_instr = indep;
    assign out_valid         = out_valid_q;
    assign out_instr         = out_instr_q;
    assign out_index         = out_index_q;

`ifdef ESM_DISPATCH_STATS_EN
    logic [31:0] stat_dispatched_q, stat_dispatched_d;
    logic [31:0] stat_dropped_q, stat_dropped_d;

    always_comb begin
        stat_dispatched_d = stat_dispatched_q + {31'd0, grant_acc};
        stat_dropped_d    = stat_dropped_q + {31'd0, valid_count && !grant_acc};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_dispatched_q <= '0;
            stat_dropped_q    <= '0;
        end else begin
            stat_dispatched_q <= stat_dispatched_d;
            stat_dropped_q    <= stat_dropped_d;
        end
    end

    assign stat_dispatched = stat_dispatched_q;
    assign stat_dropped    = stat_dropped_q;
`endif

endmodule

// File: tb/tb_esm_dispatch_buffer.sv
// tb/tb_esm_dispatch_buffer.sv - self-checking bench for esm_dispatch_buffer against an age-sequence model
module tb_esm_dispatch_buffer;

    localparam int BS = 16;
    localparam int IW = 32;
    localparam int RW = 5;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_instr = '0;
    logic [RW-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [0:BS-1] independent_instr;
    logic [SW-1:0] next_buffer_index = '0;
    logic          valid_count = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [IW-1:0] out_instr;
    logic [SW-1:0] out_index;
`ifdef ESM_DISPATCH_STATS_EN
    logic [31:0]   stat_dispatched, stat_dropped;
`endif

    always #5 clk = ~clk;

    esm_dispatch_buffer dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_instr          (in_instr),
        .in_rd             (in_rd),
        .in_rs1            (in_rs1),
        .in_rs2            (in_rs2),
        .independent_instr (independent_instr),
        .next_buffer_index (next_buffer_index),
        .valid_count       (valid_count),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_instr         (out_instr),
        .out_index         (out_index)
`ifdef ESM_DISPATCH_STATS_EN
        ,
        .stat_dispatched   (stat_dispatched),
        .stat_dropped      (stat_dropped)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: slots plus an insertion sequence number per slot
    bit            m_valid [BS];
    logic [IW-1:0] m_instr [BS];
    logic [RW-1:0] m_rd [BS], m_rs1 [BS], m_rs2 [BS];
    int            m_seq [BS];
    int            seq_ctr;
    bit            m_ov;
    logic [IW-1:0] m_oi;
    logic [SW-1:0] m_ox;
    int            m_disp, m_drop;

    function automatic void m_reset();
        for (int i = 0; i < BS; i++) begin
            m_valid[i] = 0; m_instr[i] = '0; m_rd[i] = '0; m_rs1[i] = '0; m_rs2[i] = '0; m_seq[i] = 0;
        end
        seq_ctr = 0; m_ov = 0; m_oi = '0; m_ox = '0; m_disp = 0; m_drop = 0;
    endfunction

    function automatic bit conflicts(int i, int j);
        bit raw, waw, war;
        raw = (m_rd[j] != 0) && (m_rd[j] == m_rs1[i] || m_rd[j] == m_rs2[i]);
        waw = (m_rd[i] != 0) && (m_rd[j] == m_rd[i]);
        war = (m_rd[i] != 0) && (m_rs1[j] == m_rd[i] || m_rs2[j] == m_rd[i]);
        return raw || waw || war;
    endfunction

    function automatic bit m_indep(int i);
        if (!m_valid[i]) return 0;
        for (int j = 0; j < BS; j++)
            if (j != i && m_valid[j] && m_seq[j] < m_seq[i] && conflicts(i, j)) return 0;
        return 1;
    endfunction

    function automatic logic [0:BS-1] m_bitmap();
        logic [0:BS-1] b;
        for (int i = 0; i < BS; i++) b[i] = m_indep(i);
        return b;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < BS; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    task automatic idle();
        in_valid = 0; valid_count = 0;
    endtask

    task automatic offer(input logic [IW-1:0] ins, input int rd, input int rs1, input int rs2);
        in_valid = 1; in_instr = ins; in_rd = RW'(rd); in_rs1 = RW'(rs1); in_rs2 = RW'(rs2);
    endtask

    task automatic grant(input int idx);
        valid_count = 1; next_buffer_index = SW'(idx);
    endtask

    // Advance the model by one clock using the currently driven inputs, then clock the DUT
    task automatic step();
        bit acc, ins;
        int f, g;
        g   = int'(next_buffer_index);
        acc = valid_count && m_valid[g] && m_indep(g) && (!m_ov || out_ready);
        f   = m_free();
        ins = in_valid && (f >= 0);
        if (valid_count) begin
            if (acc) m_disp++;
            else     m_drop++;
        end
        if (acc) begin
            m_ov = 1; m_oi = m_instr[g]; m_ox = SW'(g);
            m_valid[g] = 0;
        end else if (out_ready) begin
            m_ov = 0;
        end
        if (ins) begin
            m_valid[f] = 1; m_instr[f] = in_instr; m_rd[f] = in_rd;
            m_rs1[f] = in_rs1; m_rs2[f] = in_rs2; m_seq[f] = seq_ctr++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); out_ready = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        m_reset();
    endtask

    task automatic test_reset();
        do_reset();
        offer(32'hA5A5_0001, 1, 2, 3); step();
        offer(32'hA5A5_0002, 4, 5, 6); step();
        idle(); out_ready = 0; grant(0); step();
        idle();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_out_valid got=%0b exp=1", out_valid); end
        #2 rst = 0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        n_vec++; if (independent_instr !== '0) begin n_err++; $display("FAIL reset_indep got=%h exp=0", independent_instr); end
        n_vec++; if (out_valid !== 1'b0 || out_instr !== '0 || out_index !== '0) begin
            n_err++; $display("FAIL reset_out got=%0b/%h/%0d exp=0/0/0", out_valid, out_instr, out_index);
        end
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1 || independent_instr !== '0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_hold got=%0b/%h/%0b exp=1/0/0", in_ready, independent_instr, out_valid);
        end
        rst = 1; out_ready = 1;
        m_reset();
    endtask

    task automatic test_dependent_pair();
        logic [0:BS-1] exp;
        do_reset();
        offer(32'h0031_00B3, 1, 2, 3); step();
        offer(32'h4051_0233, 4, 1, 5); step();
        idle();
        exp = 16'b1000_0000_0000_0000;
        n_vec++; if (independent_instr !== exp) begin n_err++; $display("FAIL pair_bitmap got=%b exp=%b", independent_instr, exp); end
        grant(0); step(); idle();
        n_vec++; if (out_valid !== 1'b1 || out_index !== 4'd0 || out_instr !== 32'h0031_00B3) begin
            n_err++; $display("FAIL pair_dispatch got=%0b/%0d/%h exp=1/0/003100b3", out_valid, out_index, out_instr);
        end
        exp = 16'b0100_0000_0000_0000;
        n_vec++; if (independent_instr !== exp) begin n_err++; $display("FAIL pair_bit1 got=%b exp=%b", independent_instr, exp); end
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pair_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < BS; i++) begin
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_%0d got=%0b exp=1", i, in_ready); end
            offer(32'hF000_0000 + i, i + 1, 0, 0); step();
        end
        idle();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_not_ready got=%0b exp=0", in_ready); end
        n_vec++; if (independent_instr !== '1) begin n_err++; $display("FAIL full_bitmap got=%b exp=all ones", independent_instr); end
        offer(32'hDEAD_0017, 20, 0, 0); step(); idle();
        n_vec++; if (in_ready !== 1'b0 || independent_instr !== m_bitmap()) begin
            n_err++; $display("FAIL full_17th got=%0b/%b exp=0/%b", in_ready, independent_instr, m_bitmap());
        end
        grant(5); step(); idle();
        n_vec++; if (in_ready !== 1'b1 || out_instr !== 32'hF000_0005 || out_index !== 4'd5) begin
            n_err++; $display("FAIL full_grant5 got=%0b/%h/%0d exp=1/f0000005/5", in_ready, out_instr, out_index);
        end
        offer(32'hBEEF_0005, 25, 0, 0); step(); idle();
        grant(5); step(); idle();
        n_vec++; if (out_valid !== 1'b1 || out_instr !== 32'hBEEF_0005 || out_index !== 4'd5) begin
            n_err++; $display("FAIL full_reuse5 got=%0b/%h/%0d exp=1/beef0005/5", out_valid, out_instr, out_index);
        end
    endtask

    task automatic test_dropped_grants();
        logic [0:BS-1] exp;
`ifdef ESM_DISPATCH_STATS_EN
        logic [31:0] drop0, disp0;
`endif
        do_reset();
        offer(32'h1111_0000, 1, 0, 0); step();
        offer(32'h2222_0001, 2, 1, 0); step(); idle();
`ifdef ESM_DISPATCH_STATS_EN
        drop0 = stat_dropped; disp0 = stat_dispatched;
`endif
        grant(3); step(); idle();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drop_empty got=%0b exp=0", out_valid); end
        grant(1); step(); idle();
        exp = 16'b1000_0000_0000_0000;
        n_vec++; if (out_valid !== 1'b0 || independent_instr !== exp || in_ready !== 1'b1) begin
            n_err++; $display("FAIL drop_dep got=%0b/%b/%0b exp=0/%b/1", out_valid, independent_instr, in_ready, exp);
        end
`ifdef ESM_DISPATCH_STATS_EN
        n_vec++; if (stat_dropped - drop0 !== 32'd2 || stat_dispatched !== disp0) begin
            n_err++; $display("FAIL drop_stats got=%0d/%0d exp=2/%0d", stat_dropped - drop0, stat_dispatched, disp0);
        end
`endif
    endtask

    task automatic test_stall();
        do_reset();
        offer(32'hC000_0000, 1, 0, 0); step();
        offer(32'hC000_0001, 2, 0, 0); step();
        offer(32'hC000_0002, 3, 0, 0); step(); idle();
        out_ready = 0; grant(0); step();
        grant(1); step(); idle();
        n_vec++; if (out_valid !== 1'b1 || out_instr !== 32'hC000_0000 || out_index !== 4'd0) begin
            n_err++; $display("FAIL stall_hold got=%0b/%h/%0d exp=1/c0000000/0", out_valid, out_instr, out_index);
        end
        n_vec++; if (independent_instr !== 16'b0110_0000_0000_0000) begin
            n_err++; $display("FAIL stall_bitmap got=%b exp=0110000000000000", independent_instr);
        end
        out_ready = 1; grant(1); step();
        n_vec++; if (out_valid !== 1'b1 || out_instr !== 32'hC000_0001 || out_index !== 4'd1) begin
            n_err++; $display("FAIL stall_release got=%0b/%h/%0d exp=1/c0000001/1", out_valid, out_instr, out_index);
        end
        grant(2); step(); idle();
        n_vec++; if (out_valid !== 1'b1 || out_instr !== 32'hC000_0002 || out_index !== 4'd2) begin
            n_err++; $display("FAIL back_to_back got=%0b/%h/%0d exp=1/c0000002/2", out_valid, out_instr, out_index);
        end
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_reg_zero_and_simul();
        do_reset();
        offer(32'h0000_0001, 0, 7, 8); step();
        offer(32'h0000_0002, 0, 9, 10); step();
        offer(32'h0000_0003, 11, 0, 0); step(); idle();
        n_vec++; if (independent_instr !== 16'b1110_0000_0000_0000) begin
            n_err++; $display("FAIL r0_bitmap got=%b exp=1110000000000000", independent_instr);
        end
        do_reset();
        offer(32'hAAAA_0000, 1, 0, 0); step();
        offer(32'hAAAA_0001, 1, 0, 0); grant(0); step(); idle();
        n_vec++; if (out_index !== 4'd0 || independent_instr !== 16'b0100_0000_0000_0000) begin
            n_err++; $display("FAIL simul_slot1 got=%0d/%b exp=0/0100000000000000", out_index, independent_instr);
        end
        offer(32'hAAAA_0002, 1, 0, 0); step(); idle();
        n_vec++; if (independent_instr !== 16'b0100_0000_0000_0000) begin
            n_err++; $display("FAIL simul_reuse0 got=%b exp=0100000000000000", independent_instr);
        end
        grant(1); step(); idle();
        n_vec++; if (out_valid !== 1'b1 || out_instr !== 32'hAAAA_0001 || out_index !== 4'd1) begin
            n_err++; $display("FAIL simul_grant1 got=%0b/%h/%0d exp=1/aaaa0001/1", out_valid, out_instr, out_index);
        end
    endtask

    task automatic test_random();
        int q[$];
        do_reset();
        for (int c = 0; c < 800; c++) begin
            n_vec++; if (in_ready !== (m_free() >= 0)) begin
                n_err++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", c, in_ready, m_free() >= 0);
            end
            n_vec++; if (independent_instr !== m_bitmap()) begin
                n_err++; $display("FAIL rnd_bitmap cyc=%0d got=%b exp=%b", c, independent_instr, m_bitmap());
            end
            n_vec++; if (out_valid !== m_ov || (m_ov && (out_instr !== m_oi || out_index !== m_ox))) begin
                n_err++; $display("FAIL rnd_out cyc=%0d got=%0b/%h/%0d exp=%0b/%h/%0d",
                                  c, out_valid, out_instr, out_index, m_ov, m_oi, m_ox);
            end
`ifdef ESM_DISPATCH_STATS_EN
            n_vec++; if (stat_dispatched !== 32'(m_disp) || stat_dropped !== 32'(m_drop)) begin
                n_err++; $display("FAIL rnd_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", c, stat_dispatched, stat_dropped, m_disp, m_drop);
            end
`endif
            in_valid = ($urandom_range(0, 2) != 0);
            in_instr = $urandom;
            in_rd = RW'($urandom_range(0, 4));
            in_rs1 = RW'($urandom_range(0, 4));
            in_rs2 = RW'($urandom_range(0, 4));
            valid_count = ($urandom_range(0, 2) != 0);
            q.delete();
            for (int i = 0; i < BS; i++) if (m_valid[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                next_buffer_index = SW'(q[$urandom_range(0, q.size() - 1)]);
            else
                next_buffer_index = SW'($urandom_range(0, BS - 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle(); out_ready = 1;
    endtask

    initial begin
        m_reset();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        test_reset();
        test_dependent_pair();
        test_full();
        test_dropped_grants();
        test_stall();
        test_reg_zero_and_simul();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
